// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use stall, branch flush, memory freeze and forwarding control
//
// Ports:
//   Clk, Reset_n                       clock, asynchronous active-low reset
//   ID_Rn/ID_Rm/ID_Rd, ID_use_*        source registers of the ID instruction and their read flags
//   EX_Rd, EX_RF_E, EX_MEM_E           EX destination, write enable, load flag
//   MEM_Rd, MEM_RF_E, WB_Rd, WB_RF_E   later-stage destinations and write enables
//   EX_branch_taken, MEM_wait          taken branch in EX, data memory not ready
//   PC_enable, IF_ID_enable            front-end advance enables
//   IF_ID_flush, NOP_select, pipe_hold flush, bubble insertion, back-end hold
//   ForwardA/B/C                       operand source selects for Rn/Rm/Rd
//   stall_count/flush_count/freeze_count  saturating event counters
module hazard_stall_controller #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [3:0]       ID_Rn,
    input  logic [3:0]       ID_Rm,
    input  logic [3:0]       ID_Rd,
    input  logic             ID_use_Rn,
    input  logic             ID_use_Rm,
    input  logic             ID_use_Rd,
    input  logic [3:0]       EX_Rd,
    input  logic             EX_RF_E,
    input  logic             EX_MEM_E,
    input  logic [3:0]       MEM_Rd,
    input  logic [3:0]       WB_Rd,
    input  logic             MEM_RF_E,
    input  logic             WB_RF_E,
    input  logic             EX_branch_taken,
    input  logic             MEM_wait,
    output logic             PC_enable,
    output logic             IF_ID_enable,
    output logic             IF_ID_flush,
    output logic             NOP_select,
    output logic             pipe_hold,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [1:0]       ForwardC,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_count
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, FREEZE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    state_t ret_state, ret_nxt;
    state_t eff_state;
    logic   hazard;
    logic   stall_act, flush_act;

    // A loaded value in EX is not available until MEM, so ALU-result
    // forwarding from EX is suppressed for loads; r15 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       ex_en,
        input logic [3:0] ex_rd,
        input logic       mem_en,
        input logic [3:0] mem_rd,
        input logic       wb_en,
        input logic [3:0] wb_rd
    );
        if (src == 4'd15)                 return 2'b00;
        else if (ex_en && ex_rd == src)   return 2'b01;
        else if (mem_en && mem_rd == src) return 2'b10;
        else if (wb_en && wb_rd == src)   return 2'b11;
        else                              return 2'b00;
    endfunction

    assign hazard = EX_MEM_E && EX_RF_E && (EX_Rd != 4'd15) &&
                    ((ID_use_Rn && ID_Rn == EX_Rd) ||
                     (ID_use_Rm && ID_Rm == EX_Rd) ||
                     (ID_use_Rd && ID_Rd == EX_Rd));

    always_comb begin
        state_nxt    = RUN;
        ret_nxt      = ret_state;
        PC_enable    = 1'b1;
        IF_ID_enable = 1'b1;
        IF_ID_flush  = 1'b0;
        NOP_select   = 1'b0;
        pipe_hold    = 1'b0;
        stall_act    = 1'b0;
        flush_act    = 1'b0;
        // Leaving FREEZE behaves exactly like the state it interrupted.
        eff_state    = (state == FREEZE) ? ret_state : state;

        if (MEM_wait) begin
            PC_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            pipe_hold    = 1'b1;
            state_nxt    = FREEZE;
            if (state != FREEZE) ret_nxt = state;
        end else if (EX_branch_taken) begin
            // The dependent instruction is squashed, so no stall is needed.
            IF_ID_flush = 1'b1;
            NOP_select  = 1'b1;
            flush_act   = 1'b1;
        end else if (hazard && eff_state == RUN) begin
            PC_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            NOP_select   = 1'b1;
            stall_act    = 1'b1;
            state_nxt    = LOAD_STALL;
        end

        if (!Reset_n) begin
            PC_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            IF_ID_flush  = 1'b0;
            NOP_select   = 1'b1;
            pipe_hold    = 1'b0;
            stall_act    = 1'b0;
            flush_act    = 1'b0;
        end
    end

    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        ForwardC = 2'b00;
        if (Reset_n) begin
            ForwardA = fwd_sel(ID_Rn, EX_RF_E && !EX_MEM_E, EX_Rd, MEM_RF_E, MEM_Rd, WB_RF_E, WB_Rd);
            ForwardB = fwd_sel(ID_Rm, EX_RF_E && !EX_MEM_E, EX_Rd, MEM_RF_E, MEM_Rd, WB_RF_E, WB_Rd);
            ForwardC = fwd_sel(ID_Rd, EX_RF_E && !EX_MEM_E, EX_Rd, MEM_RF_E, MEM_Rd, WB_RF_E, WB_Rd);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= RUN;
            ret_state <= RUN;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_count  <= '0;
            flush_count  <= '0;
            freeze_count <= '0;
        end else begin
            if (stall_act && stall_count != '1)  stall_count  <= stall_count + CNT_ONE;
            if (flush_act && flush_count != '1)  flush_count  <= flush_count + CNT_ONE;
            if (MEM_wait && freeze_count != '1)  freeze_count <= freeze_count + CNT_ONE;
        end
    end

endmodule
